// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencing controller.
package fib_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 5;

  // Value of term 0 and term 1 of the series (1, 1, 2, 3, 5, ...).
  localparam int FIB_SEED = 1;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FIN
  } fib_state_e;

endpackage

// File: rtl/fib_seq_ctrl_if.sv
// Command and term-stream bundle between a requester/consumer and fib_seq_ctrl.
interface fib_seq_ctrl_if
  import fib_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic              start;
  logic [CNT_W-1:0]  n;
  logic              busy;
  logic [DATA_W-1:0] term;
  logic [CNT_W-1:0]  term_idx;
  logic              term_valid;
  logic              term_ready;
  logic              last;
  logic              done;
  logic              ovf;

  // Requester side: issues commands and consumes terms.
  modport master (
    output start, n, term_ready,
    input  busy, term, term_idx, term_valid, last, done, ovf
  );

  // Controller side.
  modport slave (
    input  start, n, term_ready,
    output busy, term, term_idx, term_valid, last, done, ovf
  );

endinterface

// File: rtl/fib_step.sv
// Datapath adder producing the next term; carry flags a wrapped term.
module fib_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_seq_ctrl.sv
// Clocked Fibonacci term generator: streams n terms over valid/ready, then pulses done.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  fib_seq_ctrl_if.slave bus
);

  fib_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, sum;
  logic              carry;
  logic              b_carry_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  idx_q, n_q;
  logic              is_last, accept, fire;
  logic              busy_c, valid_c, last_c, done_c;

  fib_step #(.DATA_W(DATA_W)) u_step (
    .a     (a_q),
    .b     (b_q),
    .sum   (sum),
    .carry (carry)
  );

  assign is_last = (idx_q == n_q - CNT_W'(1));
  assign accept  = (state_q == IDLE) && bus.start;
  assign fire    = (state_q == EMIT) && bus.term_ready;

  // State register; reset abandons any series in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    valid_c = 1'b0;
    last_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (bus.n == '0) ? FIN : EMIT;
      end
      EMIT: begin
        busy_c  = 1'b1;
        valid_c = 1'b1;
        last_c  = is_last;
        if (bus.term_ready && is_last) state_d = FIN;
      end
      FIN: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Term registers: a is the presented term, b the next one; ovf rises as a wrapped b moves into a.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      b_carry_q <= 1'b0;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
      n_q       <= '0;
    end else if (accept) begin
      n_q       <= bus.n;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
      a_q       <= DATA_W'(FIB_SEED);
      b_q       <= DATA_W'(FIB_SEED);
      b_carry_q <= 1'b0;
    end else if (fire && !is_last) begin
      a_q       <= b_q;
      b_q       <= sum;
      b_carry_q <= carry;
      ovf_q     <= ovf_q | b_carry_q;
      idx_q     <= idx_q + CNT_W'(1);
    end
  end

  assign bus.busy       = busy_c;
  assign bus.term_valid = valid_c;
  assign bus.last       = last_c;
  assign bus.done       = done_c;
  assign bus.term       = a_q;
  assign bus.term_idx   = idx_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed self-checking bench for fib_seq_ctrl (32-bit and 8-bit instances).
module tb_fib_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fib_seq_ctrl_if #(.DATA_W(32), .CNT_W(5)) bus32 ();
  fib_seq_ctrl_if #(.DATA_W(8),  .CNT_W(5)) bus8 ();

  fib_seq_ctrl #(.DATA_W(32), .CNT_W(5)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  fib_seq_ctrl #(.DATA_W(8), .CNT_W(5)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] fib32 [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
  logic [7:0]  fib8  [14] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
  bit          readyPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulses start with term count nv on the 32-bit instance for one cycle.
  task automatic applyStimulus(input logic [4:0] nv);
    @(negedge clk);
    bus32.start = 1'b1;
    bus32.n     = nv;
    @(posedge clk);
    #1 bus32.start = 1'b0;
  endtask

  // Follows a 32-bit stream with ready held high, then expects the done cycle.
  task automatic checkStream32(input int cnt, input string tag);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_valid%0d", tag, k), bus32.term_valid, 1);
      checkOutput($sformatf("%s_term%0d", tag, k), bus32.term, fib32[k]);
      checkOutput($sformatf("%s_idx%0d", tag, k), bus32.term_idx, k);
      checkOutput($sformatf("%s_last%0d", tag, k), bus32.last, (k == cnt - 1));
      checkOutput($sformatf("%s_busy%0d", tag, k), bus32.busy, 1);
      checkOutput($sformatf("%s_ovf%0d", tag, k), bus32.ovf, 0);
    end
    @(negedge clk);
    checkOutput($sformatf("%s_done", tag), bus32.done, 1);
    checkOutput($sformatf("%s_fin_busy", tag), bus32.busy, 0);
    checkOutput($sformatf("%s_fin_valid", tag), bus32.term_valid, 0);
  endtask

  initial begin
    int  received;
    bit  seen;

    bus32.start = 1'b0; bus32.n = '0; bus32.term_ready = 1'b1;
    bus8.start  = 1'b0; bus8.n  = '0; bus8.term_ready  = 1'b1;

    // Reset state
    #3;
    checkOutput("rst_valid", bus32.term_valid, 0);
    checkOutput("rst_busy",  bus32.busy, 0);
    checkOutput("rst_done",  bus32.done, 0);
    checkOutput("rst_ovf",   bus32.ovf, 0);
    checkOutput("rst_term",  bus32.term, 0);
    checkOutput("rst_idx",   bus32.term_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic stream, n=10: done lands in the 11th cycle counted from the start cycle
    applyStimulus(5'd10);
    checkStream32(10, "basic");
    @(negedge clk);
    checkOutput("basic_done_once", bus32.done, 0);

    // Backpressure, n=5, ready pattern 1,0,0,1,...
    applyStimulus(5'd5);
    received = 0;
    for (int cyc = 0; cyc < 40 && received < 5; cyc++) begin
      @(negedge clk);
      checkOutput("bp_valid", bus32.term_valid, 1);
      checkOutput($sformatf("bp_term%0d", received), bus32.term, fib32[received]);
      checkOutput($sformatf("bp_idx%0d", received), bus32.term_idx, received);
      checkOutput($sformatf("bp_last%0d", received), bus32.last, (received == 4));
      bus32.term_ready = readyPat[cyc % 4];
      if (bus32.term_ready) received++;
    end
    checkOutput("bp_count", received, 5);
    @(negedge clk);
    checkOutput("bp_done", bus32.done, 1);
    checkOutput("bp_fin_valid", bus32.term_valid, 0);
    bus32.term_ready = 1'b1;

    // n=0: no terms, done in the cycle after start
    applyStimulus(5'd0);
    @(negedge clk);
    checkOutput("n0_valid", bus32.term_valid, 0);
    checkOutput("n0_busy",  bus32.busy, 0);
    checkOutput("n0_done",  bus32.done, 1);
    @(negedge clk);
    checkOutput("n0_done_once", bus32.done, 0);

    // n=1: a single term with last
    applyStimulus(5'd1);
    checkStream32(1, "n1");

    // Start while busy is ignored, n is not re-sampled
    applyStimulus(5'd10);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("busy_term%0d", k), bus32.term, fib32[k]);
      checkOutput($sformatf("busy_idx%0d", k), bus32.term_idx, k);
      checkOutput($sformatf("busy_last%0d", k), bus32.last, (k == 9));
      if (k == 3) begin
        bus32.start = 1'b1;
        bus32.n     = 5'd3;
      end else begin
        bus32.start = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("busy_done", bus32.done, 1);
    // Start raised during the FIN cycle must be ignored
    bus32.start = 1'b1;
    bus32.n     = 5'd2;
    @(posedge clk);
    #1 bus32.start = 1'b0;
    @(negedge clk);
    checkOutput("fin_start_valid", bus32.term_valid, 0);
    checkOutput("fin_start_busy",  bus32.busy, 0);
    checkOutput("fin_start_done",  bus32.done, 0);
    applyStimulus(5'd3);
    checkStream32(3, "after_fin");

    // Overflow on the 8-bit instance, n=14
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.n     = 5'd14;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ovf_term%0d", k), bus8.term, fib8[k]);
      checkOutput($sformatf("ovf_idx%0d", k), bus8.term_idx, k);
      checkOutput($sformatf("ovf_flag%0d", k), bus8.ovf, (k == 13));
      checkOutput($sformatf("ovf_last%0d", k), bus8.last, (k == 13));
    end
    @(negedge clk);
    checkOutput("ovf_done", bus8.done, 1);
    checkOutput("ovf_sticky_done", bus8.ovf, 1);
    @(negedge clk);
    checkOutput("ovf_sticky_idle", bus8.ovf, 1);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.n     = 5'd1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    @(negedge clk);
    checkOutput("ovf_cleared", bus8.ovf, 0);
    checkOutput("ovf_n1_term", bus8.term, 1);
    checkOutput("ovf_n1_last", bus8.last, 1);
    @(negedge clk);
    checkOutput("ovf_n1_done", bus8.done, 1);

    // Rerun the wrapping series so reset has a set ovf to clear
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.n     = 5'd14;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus8.done) seen = 1'b1;
    end
    checkOutput("rerun_done_seen", seen, 1);
    checkOutput("rerun_ovf", bus8.ovf, 1);

    // Reset mid-stream at idx 4
    applyStimulus(5'd10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_term%0d", k), bus32.term, fib32[k]);
    end
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", bus32.term_valid, 0);
    checkOutput("mid_rst_busy",  bus32.busy, 0);
    checkOutput("mid_rst_done",  bus32.done, 0);
    checkOutput("mid_rst_ovf",   bus32.ovf, 0);
    checkOutput("mid_rst_term",  bus32.term, 0);
    checkOutput("mid_rst_idx",   bus32.term_idx, 0);
    checkOutput("mid_rst_ovf8",  bus8.ovf, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_no_done", bus32.done, 0);
    rst = 1'b0;
    applyStimulus(5'd3);
    checkStream32(3, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
